// File: rtl/core_controller_multicycle_if.sv
// Controller <-> datapath control bundle: instruction/flag in, strobes and mux selects out.
// No handshake; the controller samples Instruction/ZeroFlag combinationally every cycle.
interface core_controller_multicycle_if #(
  parameter int RETIRE_W = 32
);
  logic [31:0]         Instruction;
  logic                ZeroFlag;
  logic                PCWrite;
  logic                AdrSrc;
  logic                IRWrite;
  logic                MemWrite;
  logic                RegWrite;
  logic [1:0]          ResultSrc;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [2:0]          ImmSrc;
  logic [2:0]          ALUControl;
  logic                Halted;
  logic [RETIRE_W-1:0] RetireCount;

  modport master (
    output Instruction, ZeroFlag,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halted, RetireCount
  );

  modport slave (
    input  Instruction, ZeroFlag,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halted, RetireCount
  );
endinterface

// File: rtl/core_controller_multicycle.sv
// Moore control FSM for the multicycle RV32I core; retires instructions, halts on illegal encodings.
// Latency: lw 5, sw/R/I/jal/jalr 4, branch/lui 3 cycles; no backpressure (strobes are fire-and-forget).
module core_controller_multicycle #(
  parameter bit SUPPORT_BNE = 1'b1,
  parameter int RETIRE_W    = 32
) (
  input logic                        clk,
  input logic                        reset,
  core_controller_multicycle_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB, S_LUI, S_HALT
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t              state, next_state;
  logic [RETIRE_W-1:0] retire_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       alu_legal, br_legal, taken;
  logic       unused_instr_bits;

  assign opcode            = bus.Instruction[6:0];
  assign funct3            = bus.Instruction[14:12];
  assign funct7b5          = bus.Instruction[30];
  assign unused_instr_bits = ^{bus.Instruction[31], bus.Instruction[29:15], bus.Instruction[11:7]};

  assign alu_legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_legal  = (funct3 == 3'b000) || (SUPPORT_BNE && (funct3 == 3'b001));
  // funct3[0] separates bne from beq; only those two reach BRANCH.
  assign taken     = funct3[0] ? ~bus.ZeroFlag : bus.ZeroFlag;

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  alu_op = sub_ok ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    next_state = S_HALT;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = alu_legal ? S_EXECR : S_HALT;
          OP_I:         next_state = alu_legal ? S_EXECI : S_HALT;
          OP_BR:        next_state = br_legal ? S_BRANCH : S_HALT;
          OP_JAL:       next_state = S_JAL;
          OP_JALR:      next_state = S_JALR;
          OP_LUI:       next_state = S_LUI;
          default:      next_state = S_HALT;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      next_state = S_ALUWB;
      S_JALR:     next_state = S_JALRWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BRANCH,
      S_JALRWB,
      S_LUI:      next_state = S_FETCH;
      default:    next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      retire_q <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_FETCH && state != S_FETCH)
        retire_q <= retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  logic       pc_update, branch, adr_src, ir_write, mem_write, reg_write, halted;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_ctl, imm_src;

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctl    = ALU_ADD;
    case (state)
      S_FETCH:    begin ir_write = 1'b1; src_b = 2'b10; result_src = 2'b10; pc_update = 1'b1; end
      S_DECODE:   begin src_a = 2'b01; src_b = 2'b01; end
      S_MEMADR:   begin src_a = 2'b10; src_b = 2'b01; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      S_EXECR:    begin src_a = 2'b10; alu_ctl = alu_op(funct3, funct7b5); end
      S_EXECI:    begin src_a = 2'b10; src_b = 2'b01; alu_ctl = alu_op(funct3, 1'b0); end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH:   begin src_a = 2'b10; alu_ctl = ALU_SUB; branch = 1'b1; end
      S_JAL:      begin src_a = 2'b01; src_b = 2'b10; pc_update = 1'b1; end
      S_JALR:     begin src_a = 2'b10; src_b = 2'b01; result_src = 2'b10; pc_update = 1'b1; end
      S_JALRWB:   begin src_a = 2'b01; src_b = 2'b10; result_src = 2'b10; reg_write = 1'b1; end
      S_LUI:      begin result_src = 2'b11; reg_write = 1'b1; end
      S_HALT:     halted = 1'b1;
      default:    halted = 1'b1;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 3'b001;
      OP_BR:   imm_src = 3'b010;
      OP_LUI:  imm_src = 3'b011;
      OP_JAL:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

  // Reset forces FETCH; strobes are masked so nothing fires while it is held.
  assign bus.PCWrite     = ~reset & (pc_update | (branch & taken));
  assign bus.IRWrite     = ~reset & ir_write;
  assign bus.MemWrite    = ~reset & mem_write;
  assign bus.RegWrite    = ~reset & reg_write;
  assign bus.AdrSrc      = adr_src;
  assign bus.ResultSrc   = result_src;
  assign bus.ALUSrcA     = src_a;
  assign bus.ALUSrcB     = src_b;
  assign bus.ImmSrc      = imm_src;
  assign bus.ALUControl  = alu_ctl;
  assign bus.Halted      = halted;
  assign bus.RetireCount = retire_q;
endmodule

// File: tb/tb_core_controller_multicycle.sv
// Directed table-driven bench for core_controller_multicycle; narrow RetireCount exercises wrap.
module tb_core_controller_multicycle;
  localparam int RW = 4;

  localparam logic [31:0] ADDI = 32'h00C00193;
  localparam logic [31:0] LW   = 32'h02C02E83;
  localparam logic [31:0] SW   = 32'h02702623;
  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] BNE  = 32'h00001063;
  localparam logic [31:0] JALR = 32'h038000E7;
  localparam logic [31:0] LUI  = 32'h6AE01337;
  localparam logic [31:0] JAL  = 32'h0080006F;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] SLTI = 32'h00512093;
  localparam logic [31:0] ANDR = 32'h0020F1B3;
  localparam logic [31:0] ORI  = 32'hFFF16093;
  localparam logic [31:0] SLLI = 32'h00109093;
  localparam logic [31:0] BAD  = 32'hFFFFFFFF;

  typedef struct packed {
    logic       pcw, adr, irw, mw, rw;
    logic [1:0] res, sa, sb;
    logic [2:0] imm, alu;
    logic       halt;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    outs_t       exp;
    int          ret;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  core_controller_multicycle_if #(.RETIRE_W(RW)) bus ();

  core_controller_multicycle #(.SUPPORT_BNE(1'b1), .RETIRE_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic pcw, input logic adr, input logic irw,
                               input logic mw, input logic rw, input logic [1:0] res,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic [2:0] imm, input logic [2:0] alu, input logic halt);
    mk = '{pcw, adr, irw, mw, rw, res, sa, sb, imm, alu, halt};
  endfunction

  task automatic add(input logic [31:0] i, input logic z, input outs_t e, input int r,
                     input string nm);
    vec_t v;
    v.instr = i; v.zero = z; v.exp = e; v.ret = r; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input outs_t e, input int r);
    outs_t          act;
    logic [RW-1:0]  r_exp;
    r_exp = r[RW-1:0];
    act = '{bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.Halted};
    checks++;
    if (act !== e || bus.RetireCount !== r_exp) begin
      errors++;
      $display("FAIL %s: got outs=%05h retire=%0d, want outs=%05h retire=%0d",
               nm, act, bus.RetireCount, e, r_exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge, compare just after, then advance a full cycle.
  task automatic step(input logic [31:0] i, input logic z, input outs_t e, input int r,
                      input string nm);
    bus.Instruction = i;
    bus.ZeroFlag    = z;
    #1;
    cmp(nm, e, r);
    @(negedge clk);
  endtask

  // Per-state expected outputs, field order: pcw adr irw mw rw res sa sb imm alu halt
  function automatic outs_t o_fetch(input logic [2:0] imm);  o_fetch  = mk(1,0,1,0,0, 2,0,2, imm,0,0); endfunction
  function automatic outs_t o_dec(input logic [2:0] imm);    o_dec    = mk(0,0,0,0,0, 0,1,1, imm,0,0); endfunction
  function automatic outs_t o_aluwb(input logic [2:0] imm);  o_aluwb  = mk(0,0,0,0,1, 0,0,0, imm,0,0); endfunction
  function automatic outs_t o_rst(input logic [2:0] imm);    o_rst    = mk(0,0,0,0,0, 2,0,2, imm,0,0); endfunction

  initial begin
    reset           = 1'b1;
    bus.Instruction = 32'h0;
    bus.ZeroFlag    = 1'b0;

    add(ADDI,0, o_fetch(0),                   0, "addi_fetch");
    add(ADDI,0, o_dec(0),                     0, "addi_decode");
    add(ADDI,0, mk(0,0,0,0,0, 0,2,1, 0,0,0),  0, "addi_execi");
    add(ADDI,0, o_aluwb(0),                   0, "addi_aluwb");
    add(LW,0,   o_fetch(0),                   1, "lw_fetch");
    add(LW,0,   o_dec(0),                     1, "lw_decode");
    add(LW,0,   mk(0,0,0,0,0, 0,2,1, 0,0,0),  1, "lw_memadr");
    add(LW,0,   mk(0,1,0,0,0, 0,0,0, 0,0,0),  1, "lw_memread");
    add(LW,0,   mk(0,0,0,0,1, 1,0,0, 0,0,0),  1, "lw_memwb");
    add(SW,0,   o_fetch(1),                   2, "sw_fetch");
    add(SW,0,   o_dec(1),                     2, "sw_decode");
    add(SW,0,   mk(0,0,0,0,0, 0,2,1, 1,0,0),  2, "sw_memadr");
    add(SW,0,   mk(0,1,0,1,0, 0,0,0, 1,0,0),  2, "sw_memwrite");
    add(BEQ,1,  o_fetch(2),                   3, "beqT_fetch");
    add(BEQ,1,  o_dec(2),                     3, "beqT_decode");
    add(BEQ,1,  mk(1,0,0,0,0, 0,2,0, 2,1,0),  3, "beqT_branch");
    add(BEQ,0,  o_fetch(2),                   4, "beqN_fetch");
    add(BEQ,0,  o_dec(2),                     4, "beqN_decode");
    add(BEQ,0,  mk(0,0,0,0,0, 0,2,0, 2,1,0),  4, "beqN_branch");
    add(BNE,0,  o_fetch(2),                   5, "bne_fetch");
    add(BNE,0,  o_dec(2),                     5, "bne_decode");
    add(BNE,0,  mk(1,0,0,0,0, 0,2,0, 2,1,0),  5, "bne_branch");
    add(JALR,0, o_fetch(0),                   6, "jalr_fetch");
    add(JALR,0, o_dec(0),                     6, "jalr_decode");
    add(JALR,0, mk(1,0,0,0,0, 2,2,1, 0,0,0),  6, "jalr_exec");
    add(JALR,0, mk(0,0,0,0,1, 2,1,2, 0,0,0),  6, "jalr_wb");
    add(LUI,0,  o_fetch(3),                   7, "lui_fetch");
    add(LUI,0,  o_dec(3),                     7, "lui_decode");
    add(LUI,0,  mk(0,0,0,0,1, 3,0,0, 3,0,0),  7, "lui_exec");
    add(JAL,0,  o_fetch(4),                   8, "jal_fetch");
    add(JAL,0,  o_dec(4),                     8, "jal_decode");
    add(JAL,0,  mk(1,0,0,0,0, 0,1,2, 4,0,0),  8, "jal_exec");
    add(JAL,0,  o_aluwb(4),                   8, "jal_aluwb");
    add(SUB,0,  o_fetch(0),                   9, "sub_fetch");
    add(SUB,0,  o_dec(0),                     9, "sub_decode");
    add(SUB,0,  mk(0,0,0,0,0, 0,2,0, 0,1,0),  9, "sub_execr");
    add(SUB,0,  o_aluwb(0),                   9, "sub_aluwb");
    add(SLTI,0, o_fetch(0),                  10, "slti_fetch");
    add(SLTI,0, o_dec(0),                    10, "slti_decode");
    add(SLTI,0, mk(0,0,0,0,0, 0,2,1, 0,5,0), 10, "slti_execi");
    add(SLTI,0, o_aluwb(0),                  10, "slti_aluwb");
    add(ANDR,0, o_fetch(0),                  11, "and_fetch");
    add(ANDR,0, o_dec(0),                    11, "and_decode");
    add(ANDR,0, mk(0,0,0,0,0, 0,2,0, 0,2,0), 11, "and_execr");
    add(ANDR,0, o_aluwb(0),                  11, "and_aluwb");
    add(ORI,0,  o_fetch(0),                  12, "ori_fetch");
    add(ORI,0,  o_dec(0),                    12, "ori_decode");
    add(ORI,0,  mk(0,0,0,0,0, 0,2,1, 0,3,0), 12, "ori_execi");
    add(ORI,0,  o_aluwb(0),                  12, "ori_aluwb");

    #2;
    cmp("reset_hold_a", o_rst(0), 0);
    @(negedge clk);
    @(negedge clk);
    cmp("reset_hold_b", o_rst(0), 0);
    reset = 1'b0;

    foreach (vecs[k]) step(vecs[k].instr, vecs[k].zero, vecs[k].exp, vecs[k].ret, vecs[k].name);

    // Three more lui bring the 4-bit count from 13 through 15 and wrap it to 0.
    for (int n = 13; n < 16; n++) begin
      step(LUI, 0, o_fetch(3),                  n, "wrap_fetch");
      step(LUI, 0, o_dec(3),                    n, "wrap_decode");
      step(LUI, 0, mk(0,0,0,0,1, 3,0,0, 3,0,0), n, "wrap_lui");
    end

    // Illegal funct3 on an I-type op halts after DECODE.
    step(SLLI, 0, o_fetch(0), 0, "slli_fetch");
    step(SLLI, 0, o_dec(0),   0, "slli_decode");
    step(SLLI, 0, mk(0,0,0,0,0, 0,0,0, 0,0,1), 0, "slli_halt_a");
    step(SLLI, 1, mk(0,0,0,0,0, 0,0,0, 0,0,1), 0, "slli_halt_b");
    reset = 1'b1;
    #1;
    cmp("reset_from_halt", o_rst(0), 0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset in the middle of MEMADR abandons the load at once.
    step(LW, 0, o_fetch(0), 0, "lwrst_fetch");
    step(LW, 0, o_dec(0),   0, "lwrst_decode");
    bus.Instruction = LW;
    #1;
    cmp("lwrst_memadr", mk(0,0,0,0,0, 0,2,1, 0,0,0), 0);
    #1;
    reset = 1'b1;
    #1;
    cmp("reset_mid_memadr", o_rst(0), 0);
    @(negedge clk);
    reset = 1'b0;

    step(ADDI, 0, o_fetch(0),                  0, "addi2_fetch");
    step(ADDI, 0, o_dec(0),                    0, "addi2_decode");
    step(ADDI, 0, mk(0,0,0,0,0, 0,2,1, 0,0,0), 0, "addi2_execi");
    step(ADDI, 0, o_aluwb(0),                  0, "addi2_aluwb");
    step(BAD,  0, o_fetch(0),                  1, "bad_fetch");
    step(BAD,  0, o_dec(0),                    1, "bad_decode");
    for (int c = 0; c < 12; c++)
      step(BAD, c[0], mk(0,0,0,0,0, 0,0,0, 0,0,1), 1, "bad_halt");

    reset = 1'b1;
    #1;
    cmp("reset_clears_count", o_rst(0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
